// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I pipeline.
// ALU op codes, forward-mux selects and datapath widths.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the EX stage.
// Unsupported op codes yield zero.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    logic sltBit;

    assign sltBit = ($signed(SrcA) < $signed(SrcB));

    // Select the operation result.
    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, sltBit};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU, beq resolution
// and the EX/MEM pipeline register.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int REGW = riscv_pkg::REGW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            FlushE,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [REGW-1:0] RD_E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [REGW-1:0] RD_M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] fwdB;
    logic [XLEN-1:0] srcB;
    logic [XLEN-1:0] aluResult;
    logic            zero;

    // Operand A forward mux; code 11 behaves like the register file path.
    always_comb begin
        srcA = RD1_E;
        case (ForwardA_E)
            FWD_WB:  srcA = ResultW;
            FWD_MEM: srcA = ALUResultM;
            default: srcA = RD1_E;
        endcase
    end

    // Operand B forward mux; its output is also the store data.
    always_comb begin
        fwdB = RD2_E;
        case (ForwardB_E)
            FWD_WB:  fwdB = ResultW;
            FWD_MEM: fwdB = ALUResultM;
            default: fwdB = RD2_E;
        endcase
    end

    assign srcB = ALUSrcE ? Imm_Ext_E : fwdB;

    alu #(.XLEN(XLEN)) uAlu (
        .SrcA       (srcA),
        .SrcB       (srcB),
        .ALUControl (ALUControlE),
        .Result     (aluResult),
        .Zero       (zero)
    );

    assign PCSrcE    = BranchE & zero & ~FlushE;
    assign PCTargetE = PCE + Imm_Ext_E;

    // EX/MEM register: a flush kills control and RD, data still loads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE & ~FlushE;
            MemWriteM  <= MemWriteE & ~FlushE;
            ResultSrcM <= ResultSrcE & ~FlushE;
            RD_M       <= FlushE ? '0 : RD_E;
            ALUResultM <= aluResult;
            WriteDataM <= fwdB;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed vector table
// followed by random stimulus against a reference model.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        FlushE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .FlushE      (FlushE),
        .RegWriteE   (RegWriteE),
        .ALUSrcE     (ALUSrcE),
        .MemWriteE   (MemWriteE),
        .ResultSrcE  (ResultSrcE),
        .BranchE     (BranchE),
        .ALUControlE (ALUControlE),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .Imm_Ext_E   (Imm_Ext_E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .RD_E        (RD_E),
        .ForwardA_E  (ForwardA_E),
        .ForwardB_E  (ForwardB_E),
        .ResultW     (ResultW),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M)
    );

    typedef struct {
        logic        rstN;
        logic        flush;
        logic        regW;
        logic        aluSrc;
        logic        memW;
        logic        resSrc;
        logic        branch;
        logic [2:0]  op;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] resW;
        logic [4:0]  rd;
        logic        xPcSrc;
        logic [31:0] xTarget;
        logic [31:0] xAluM;
        logic [2:0]  xCtrl;
        logic [4:0]  xRdM;
        logic [31:0] xWd;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst         = v.rstN;
        FlushE      = v.flush;
        RegWriteE   = v.regW;
        ALUSrcE     = v.aluSrc;
        MemWriteE   = v.memW;
        ResultSrcE  = v.resSrc;
        BranchE     = v.branch;
        ALUControlE = v.op;
        ForwardA_E  = v.fa;
        ForwardB_E  = v.fb;
        RD1_E       = v.rd1;
        RD2_E       = v.rd2;
        Imm_Ext_E   = v.imm;
        PCE         = v.pc;
        PCPlus4E    = v.pc + 32'd4;
        ResultW     = v.resW;
        RD_E        = v.rd;
    endtask

    function automatic logic [31:0] aluRef(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel,
                                         input logic [31:0] rf,
                                         input logic [31:0] wb,
                                         input logic [31:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return rf;
    endfunction

    initial begin
        vec_t        v;
        logic [31:0] modelAluM;
        logic [31:0] a, b, res;
        logic        xPc;

        // rstN flush regW aluSrc memW resSrc branch op fa fb
        // rd1 rd2 imm pc resW rd | pcSrc target aluM ctrl rdM wd
        vecs[0]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,3'd0,2'd0,2'd0,
                     32'h7,32'h9,32'h3,32'h40,32'h0,5'd3,
                     1'b0,32'h43,32'h0,3'b000,5'd0,32'h0};
        vecs[1]  = vecs[0];
        vecs[2]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,2'd0,2'd0,
                     32'h0,32'h55,32'h5,32'h100,32'h0,5'd6,
                     1'b0,32'h105,32'h5,3'b100,5'd6,32'h55};
        vecs[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,2'd0,2'd2,
                     32'h3,32'h99,32'h0,32'h104,32'h0,5'd7,
                     1'b0,32'h104,32'h8,3'b100,5'd7,32'h5};
        vecs[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,2'd1,2'd0,
                     32'h77,32'h4,32'h0,32'h108,32'hA,5'd8,
                     1'b0,32'h108,32'hE,3'b100,5'd8,32'h4};
        vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'd1,2'd0,2'd0,
                     32'h10,32'h10,32'hC,32'h20,32'h0,5'd0,
                     1'b1,32'h2C,32'h0,3'b000,5'd0,32'h10};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'd1,2'd0,2'd0,
                     32'h10,32'h11,32'hC,32'h20,32'h0,5'd0,
                     1'b0,32'h2C,32'hFFFFFFFF,3'b000,5'd0,32'h11};
        vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'd5,2'd0,2'd0,
                     32'hFFFFFFFF,32'h1,32'h8,32'h200,32'h0,5'd9,
                     1'b0,32'h208,32'h1,3'b100,5'd9,32'h1};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'd0,2'd0,2'd0,
                     32'hFFFFFFFF,32'h1,32'hFFFFFFF8,32'h300,32'h0,5'd0,
                     1'b1,32'h2F8,32'h0,3'b000,5'd0,32'h1};
        vecs[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,2'd0,2'd0,
                     32'h1000,32'hABCD,32'h4,32'h400,32'h0,5'd12,
                     1'b0,32'h404,32'h1004,3'b000,5'd0,32'hABCD};
        vecs[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,3'd1,2'd0,2'd0,
                     32'h5,32'h5,32'h10,32'h500,32'h0,5'd10,
                     1'b0,32'h510,32'h0,3'b000,5'd0,32'h5};
        vecs[11] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,3'd0,2'd0,2'd0,
                     32'h2000,32'h33,32'h8,32'h600,32'h0,5'd13,
                     1'b0,32'h608,32'h2008,3'b101,5'd13,32'h33};
        vecs[12] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,3'd0,2'd0,2'd0,
                     32'h1,32'h44,32'h1,32'h700,32'h0,5'd14,
                     1'b0,32'h701,32'h0,3'b000,5'd0,32'h0};
        vecs[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'd3,2'd2,2'd0,
                     32'h123,32'hF0F0,32'h0,32'h800,32'h0,5'd5,
                     1'b0,32'h800,32'hF0F0,3'b100,5'd5,32'hF0F0};
        vecs[14] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'd2,2'd3,2'd3,
                     32'hFF00FF00,32'h0FF00FF0,32'h0,32'h0,32'h0,5'd15,
                     1'b0,32'h0,32'h0F000F00,3'b100,5'd15,32'h0FF00FF0};
        vecs[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'd4,2'd0,2'd0,
                     32'h5,32'h6,32'h20,32'h10,32'h0,5'd0,
                     1'b1,32'h30,32'h0,3'b000,5'd0,32'h6};
        vecs[16] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,3'd1,2'd0,2'd1,
                     32'h50,32'h999,32'h0,32'h900,32'h20,5'd0,
                     1'b0,32'h900,32'h30,3'b110,5'd0,32'h20};

        drive(vecs[0]);
        #2;
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            drive(v);
            #1;
            chk($sformatf("v%0d PCSrcE", i), {31'b0, PCSrcE}, {31'b0, v.xPcSrc});
            chk($sformatf("v%0d PCTargetE", i), PCTargetE, v.xTarget);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ALUResultM", i), ALUResultM, v.xAluM);
            chk($sformatf("v%0d ctrlM", i),
                {29'b0, RegWriteM, MemWriteM, ResultSrcM}, {29'b0, v.xCtrl});
            chk($sformatf("v%0d RD_M", i), {27'b0, RD_M}, {27'b0, v.xRdM});
            chk($sformatf("v%0d WriteDataM", i), WriteDataM, v.xWd);
            chk($sformatf("v%0d PCPlus4M", i), PCPlus4M,
                v.rstN ? v.pc + 32'd4 : 32'd0);
        end

        modelAluM = vecs[NV-1].xAluM;
        for (int i = 0; i < 400; i++) begin
            v.rstN   = ($urandom_range(0, 19) != 0);
            v.flush  = ($urandom_range(0, 6) == 0);
            v.regW   = 1'($urandom);
            v.aluSrc = 1'($urandom);
            v.memW   = 1'($urandom);
            v.resSrc = 1'($urandom);
            v.branch = 1'($urandom);
            v.op     = 3'($urandom);
            v.fa     = 2'($urandom);
            v.fb     = 2'($urandom);
            v.rd1    = $urandom;
            v.rd2    = $urandom;
            v.imm    = $urandom;
            v.pc     = $urandom;
            v.resW   = $urandom;
            v.rd     = 5'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                v.op = 3'd1; v.fa = 2'd0; v.fb = 2'd0;
                v.aluSrc = 1'b0; v.rd2 = v.rd1;
            end
            a   = pick(v.fa, v.rd1, v.resW, modelAluM);
            b   = pick(v.fb, v.rd2, v.resW, modelAluM);
            res = aluRef(v.op, a, v.aluSrc ? v.imm : b);
            xPc = v.branch && (res == 32'd0) && !v.flush;
            drive(v);
            #1;
            chk("rnd PCSrcE", {31'b0, PCSrcE}, {31'b0, xPc});
            chk("rnd PCTargetE", PCTargetE, v.pc + v.imm);
            @(posedge clk);
            #1;
            if (!v.rstN) begin
                modelAluM = 32'd0;
                chk("rnd rst ALUResultM", ALUResultM, 32'd0);
                chk("rnd rst ctrlM", {29'b0, RegWriteM, MemWriteM, ResultSrcM}, 32'd0);
                chk("rnd rst RD_M", {27'b0, RD_M}, 32'd0);
                chk("rnd rst WriteDataM", WriteDataM, 32'd0);
                chk("rnd rst PCPlus4M", PCPlus4M, 32'd0);
            end else begin
                modelAluM = res;
                chk("rnd ALUResultM", ALUResultM, res);
                chk("rnd ctrlM", {29'b0, RegWriteM, MemWriteM, ResultSrcM},
                    v.flush ? 32'd0 : {29'b0, v.regW, v.memW, v.resSrc});
                chk("rnd RD_M", {27'b0, RD_M}, v.flush ? 32'd0 : {27'b0, v.rd});
                chk("rnd WriteDataM", WriteDataM, b);
                chk("rnd PCPlus4M", PCPlus4M, v.pc + 32'd4);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
